// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: MEM stage with byte/half/word data RAM and a memory-mapped timer/IO window.
// Optional define MEM_MISALIGN_TRAP_EN flags misaligned accesses and squashes their effects.
module pipeline_mem_stage #(
  parameter int RAM_WORDS = 256,
  parameter int LED_W     = 8,
  parameter int SW_W      = 8,
  parameter int DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_out_addr,
  output logic [31:0]       mem_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout,
  output logic              misalign
);

  localparam int AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    OFF_TH   = 3'd0,
    OFF_TL   = 3'd1,
    OFF_TCON = 3'd2,
    OFF_LED  = 3'd3,
    OFF_SW   = 3'd4,
    OFF_DIGI = 3'd5,
    OFF_TICK = 3'd6,
    OFF_NONE = 3'd7
  } periph_off_e;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       th_q, th_d, tl_q, tl_d, systick_q, systick_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;

  logic              is_periph, wr_ok, ram_we, ovf_set;
  logic [AW-1:0]     ram_idx;
  logic [31:0]       ram_word, lane_mask, lane_data, ram_wdata, ram_load, periph_load;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  periph_off_e       off;
  logic              unused_addr_bits;

  // mem_rd / mem_wr are single-cycle requests with no backpressure: a load is answered
  // combinationally in its own cycle, a store commits on the rising edge ending its cycle.
  assign is_periph        = mem_addr[30];
  assign ram_idx          = mem_addr[AW+1:2];
  assign off              = periph_off_e'(mem_addr[4:2]);
  assign mem_out_addr     = mem_addr;
  assign ram_word         = ram_q[ram_idx];
  assign unused_addr_bits = ^{mem_addr[31], mem_addr[29:AW+2]};

  always_comb begin
    misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (mem_rd || mem_wr)
      misalign = ((mem_size == 2'b01) && mem_addr[0]) ||
                 (mem_size[1] && (mem_addr[1:0] != 2'b00));
`endif
  end

  assign wr_ok  = mem_wr && !misalign;
  assign ram_we = wr_ok && !is_periph && !reset;

  // Lane selection only looks at the address bits relevant to the size, which forces alignment.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_data = mem_wdata;
    case (mem_size)
      2'b00: begin
        lane_mask = 32'h0000_00FF << {mem_addr[1:0], 3'b000};
        lane_data = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = mem_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
    ram_wdata = (ram_word & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    ld_byte  = ram_word[{mem_addr[1:0], 3'b000} +: 8];
    ld_half  = mem_addr[1] ? ram_word[31:16] : ram_word[15:0];
    ram_load = ram_word;
    case (mem_size)
      2'b00:   ram_load = mem_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ram_load = mem_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    periph_load = '0;
    case (off)
      OFF_TH:   periph_load = th_q;
      OFF_TL:   periph_load = tl_q;
      OFF_TCON: periph_load[2:0] = tcon_q;
      OFF_LED:  periph_load[LED_W-1:0] = led_q;
      OFF_SW:   periph_load[SW_W-1:0] = switch;
      OFF_DIGI: periph_load[DIGI_W-1:0] = digi_q;
      OFF_TICK: periph_load = systick_q;
      default:  ;
    endcase
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_rd && !misalign)
      mem_rdata = is_periph ? periph_load : ram_load;
  end

  // Timer update first, CPU write second so the write wins; the overflow flag is OR-ed last
  // so a simultaneous software clear cannot lose an interrupt.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;
    ovf_set   = 1'b0;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d    = th_q;
        ovf_set = tcon_q[1];
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wr_ok && is_periph) begin
      case (off)
        OFF_TH:   th_d   = mem_wdata;
        OFF_TL:   tl_d   = mem_wdata;
        OFF_TCON: tcon_d = mem_wdata[2:0];
        OFF_LED:  led_d  = mem_wdata[LED_W-1:0];
        OFF_DIGI: digi_d = mem_wdata[DIGI_W-1:0];
        default:  ;
      endcase
    end
    tcon_d[2] = tcon_d[2] | ovf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  // RAM contents survive reset; only the write enable is blocked while reset is high.
  always_ff @(posedge clk) begin
    if (ram_we)
      ram_q[ram_idx] <= ram_wdata;
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2];

endmodule
